// File: rtl/sccb_write_engine.sv
// SCCB 3-phase write master: accepts one {id, reg_addr, value} command per
// handshake and serialises it onto sioc/siod with START, 27 bits and STOP.
module sccb_write_engine #(
    parameter int QUARTER    = 125,
    parameter int GAP_CYCLES = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       send,
    input  logic [7:0] id,
    input  logic [7:0] reg_addr,
    input  logic [7:0] value,
    output logic       taken,
    output logic       busy,
    output logic       sioc,
    inout  wire        siod
);

    localparam int Q_W = (QUARTER > 1) ? $clog2(QUARTER) : 1;
    localparam int G_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [Q_W-1:0] Q_LAST   = Q_W'(QUARTER - 1);
    localparam logic [Q_W-1:0] Q_ONE    = Q_W'(1);
    localparam logic [G_W-1:0] G_LAST   = G_W'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);
    localparam logic [G_W-1:0] G_ONE    = G_W'(1);
    localparam logic           HAS_GAP  = (GAP_CYCLES > 0);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_BITS  = 3'd2,
        ST_STOP  = 3'd3,
        ST_GAP   = 3'd4
    } state_t;

    state_t         state_r,  state_s;
    logic [Q_W-1:0] q_cnt_r,  q_cnt_s;
    logic [1:0]     phase_r,  phase_s;
    logic [4:0]     bit_r,    bit_s;
    logic [G_W-1:0] gap_r,    gap_s;
    logic [26:0]    shift_r,  shift_s;
    logic           taken_r,  taken_s;
    logic           busy_r,   busy_s;
    logic           sioc_r,   sioc_s;
    logic           siod_o_r, siod_o_s;
    logic           siod_oe_r, siod_oe_s;
    logic           q_wrap_s;
    logic           phase_end_s;

    // Bit slots 8, 17 and 26 belong to the camera (don't-care / ACK).
    function automatic logic is_ack_slot(input logic [4:0] idx);
        return (idx == 5'd8) || (idx == 5'd17) || (idx == 5'd26);
    endfunction

    // Next-state, counter and shift-word logic.
    always_comb begin
        state_s     = state_r;
        q_cnt_s     = q_cnt_r;
        phase_s     = phase_r;
        bit_s       = bit_r;
        gap_s       = gap_r;
        shift_s     = shift_r;
        taken_s     = 1'b0;
        q_wrap_s    = (q_cnt_r == Q_LAST);
        phase_end_s = q_wrap_s && (phase_r == 2'd3);

        if (state_r inside {ST_START, ST_BITS, ST_STOP}) begin
            if (q_wrap_s) begin
                q_cnt_s = '0;
                phase_s = phase_r + 2'd1;
            end else begin
                q_cnt_s = q_cnt_r + Q_ONE;
            end
        end else begin
            q_cnt_s = q_cnt_r;
        end

        case (state_r)
            ST_IDLE: begin
                if (send) begin
                    state_s = ST_START;
                    q_cnt_s = '0;
                    phase_s = 2'd0;
                    bit_s   = 5'd0;
                    gap_s   = '0;
                    // Don't-care slots hold 1 so the line idles high if ever driven.
                    shift_s = {id, 1'b1, reg_addr, 1'b1, value, 1'b1};
                    taken_s = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (phase_end_s) begin
                    state_s = ST_BITS;
                    bit_s   = 5'd0;
                end else begin
                    state_s = ST_START;
                end
            end
            ST_BITS: begin
                if (phase_end_s) begin
                    if (bit_r == 5'd26) begin
                        state_s = ST_STOP;
                    end else begin
                        bit_s   = bit_r + 5'd1;
                        shift_s = {shift_r[25:0], 1'b0};
                    end
                end else begin
                    state_s = ST_BITS;
                end
            end
            ST_STOP: begin
                if (phase_end_s) begin
                    if (HAS_GAP) begin
                        state_s = ST_GAP;
                        gap_s   = '0;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end else begin
                    state_s = ST_STOP;
                end
            end
            ST_GAP: begin
                if (gap_r == G_LAST) begin
                    state_s = ST_IDLE;
                end else begin
                    gap_s = gap_r + G_ONE;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Line levels derived from the next state so the registered pins align with it.
    always_comb begin
        sioc_s    = 1'b1;
        siod_o_s  = 1'b1;
        siod_oe_s = 1'b1;
        busy_s    = (state_s != ST_IDLE);
        case (state_s)
            ST_START: begin
                sioc_s   = (phase_s != 2'd3);
                siod_o_s = (phase_s == 2'd0);
            end
            ST_BITS: begin
                sioc_s    = phase_s[1];
                siod_o_s  = shift_s[26];
                siod_oe_s = !is_ack_slot(bit_s);
            end
            ST_STOP: begin
                sioc_s   = (phase_s != 2'd0);
                siod_o_s = phase_s[1];
            end
            default: begin
                sioc_s   = 1'b1;
                siod_o_s = 1'b1;
            end
        endcase
    end

    // State, counters and registered outputs; reset aborts any frame with lines high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            q_cnt_r   <= '0;
            phase_r   <= 2'd0;
            bit_r     <= 5'd0;
            gap_r     <= '0;
            shift_r   <= 27'd0;
            taken_r   <= 1'b0;
            busy_r    <= 1'b0;
            sioc_r    <= 1'b1;
            siod_o_r  <= 1'b1;
            siod_oe_r <= 1'b1;
        end else begin
            state_r   <= state_s;
            q_cnt_r   <= q_cnt_s;
            phase_r   <= phase_s;
            bit_r     <= bit_s;
            gap_r     <= gap_s;
            shift_r   <= shift_s;
            taken_r   <= taken_s;
            busy_r    <= busy_s;
            sioc_r    <= sioc_s;
            siod_o_r  <= siod_o_s;
            siod_oe_r <= siod_oe_s;
        end
    end

    assign taken = taken_r;
    assign busy  = busy_r;
    assign sioc  = sioc_r;
    assign siod  = siod_oe_r ? siod_o_r : 1'bz;

endmodule

// File: doc/sccb_write_engine.md
# sccb_write_engine

SCCB (I2C-compatible) 3-phase write master that drives the OV7670 configuration bus. It sits between the camera controller and the camera pins. It accepts one {device id, register address, value} command per handshake, acknowledges acceptance with a one-cycle `taken` pulse, and serialises the command onto `sioc`/`siod`. The register-table sequencer advances on `taken` and keeps `send` high until its table is exhausted.

## Interface

Parameters:
- QUARTER, 125, `clk` cycles per quarter SCL period (125 at 50 MHz gives 100 kHz SCL); legal range is 2 or more.
- GAP_CYCLES, 0, idle `clk` cycles inserted after STOP before the next command is accepted.

Ports (clock and reset first):
- clk  input  1  system clock; the only clock.
- rst_n  input  1  asynchronous, active-low reset.
- send  input  1  command valid; sampled only in IDLE.
- id  input  8  SCCB device write address (0x42 for OV7670).
- reg_addr  input  8  sub-address.
- value  input  8  write data.
- taken  output  1  one-cycle pulse: command captured, so the upstream block may advance.
- busy  output  1  high from acceptance until return to IDLE.
- sioc  output  1  SCCB clock.
- siod  inout  1  SCCB data; driven 0/1, or released ('z') during don't-care bits.

## Operation

- Reset (asynchronous, all outputs): IDLE, `sioc`=1, `siod`=1, `taken`=0, `busy`=0, all counters 0.
- States:
  - IDLE: `sioc`=1, `siod`=1. On a `clk` edge with `send`=1, latch a 27-bit shift word built as {id, z, reg_addr, z, value, z}. Then go to START, register `taken`=1 for the next cycle, and set `busy`=1.
  - START: 4 quarters of (`sioc`, `siod`): (1,1), (1,0), (1,0), (0,0).
  - BITS: 27 bits, MSB first within each byte. Bit indices 8, 17 and 26 are don't-care: `siod`='z' and the line is not sampled. Each bit spans 4 quarters with `sioc` = 0, 0, 1, 1. `siod` changes only at the start of quarter 0.
  - STOP: 4 quarters of (`sioc`, `siod`): (0,0), (1,0), (1,1), (1,1).
  - GAP: `sioc`=1, `siod`=1 for GAP_CYCLES cycles. Skipped when GAP_CYCLES=0. Then go to IDLE.
- Counters:
  - Quarter divider counts 0..QUARTER-1.
  - Phase counter counts 0..3.
  - Bit index counts 0..26.
  - Gap counter is wide enough for GAP_CYCLES.
- Inputs `id`, `reg_addr` and `value` are ignored outside the acceptance edge. Changes mid-transaction have no effect.
- `send` held high continuously produces back-to-back transactions with no extra idle beyond GAP_CYCLES plus 1 IDLE cycle.
- `send` dropping mid-transaction does not abort it.
- `rst_n` asserted mid-transaction aborts immediately: lines return to 1/1 with no STOP generated. After deassertion the block is in IDLE.

## Timing

- Acceptance edge N: `taken`=1 during cycle N+1 only; `busy` rises at N+1.
- Transaction length from START entry to GAP entry: (4 + 27×4 + 4)×QUARTER = 116×QUARTER cycles.
- Next acceptance edge is at least 116×QUARTER + GAP_CYCLES + 1 cycles after the previous one.
- `busy` falls on the cycle IDLE is re-entered.
- All outputs are registered. `siod` tri-state enable is registered in step with the data.
- `taken` never pulses twice per transaction and never pulses while `busy` was already high.

## Test plan

- Single write, QUARTER=4, GAP_CYCLES=0: `send` pulse with 0x42/0x12/0x80 -> `taken` high exactly 1 cycle; the bus decodes as START, 0x42, z, 0x12, z, 0x80, z, STOP; transaction is 464 cycles; `busy` low afterward.
- `send` held high, QUARTER=4, GAP_CYCLES=10: commands 0x42/0x11/0x01 then 0x42/0x6B/0x4A -> second `taken` exactly 475 cycles after the first; both frames decode correctly.
- Don't-care bits: monitor `siod` at bit indices 8, 17, 26 -> reads 'z' for all 4 quarters; `siod` is never 'z' elsewhere.
- Input change mid-frame: alter `value` to 0xFF during BITS -> the transmitted value is still 0x80.
- Reset mid-frame: assert `rst_n`=0 at bit index 12 -> `sioc`=1, `siod`=1, `busy`=0 asynchronously. After release with `send`=1, a full correct frame follows.
- Idle hold: `send`=0 for 1000 cycles after reset -> `sioc`=1, `siod`=1, `taken`=0 throughout.
